// File: rtl/lsu_axil_if.sv
// lsu_axil_if: AXI4-Lite bundle between the load/store unit and the bus fabric
interface lsu_axil_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NBYTES = XLEN / 8;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [XLEN-1:0]   wdata;
    logic [NBYTES-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [XLEN-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );
    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/lsu_axil.sv
// lsu_axil: load/store unit with byte-lane placement, misalign/bus-error flags and an AXI4-Lite master
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 4
`define LSU_NOP 4'b0000
`define LSU_LB  4'b0010
`define LSU_LH  4'b0100
`define LSU_LW  4'b0110
`define LSU_LBU 4'b1000
`define LSU_LHU 4'b1010
`define LSU_SB  4'b0011
`define LSU_SH  4'b0101
`define LSU_SW  4'b0111
`endif
module lsu_axil #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [`LSU_OPT_WIDTH-1:0] i_opt,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [XLEN-1:0]           i_regst,
    output logic [XLEN-1:0]           o_regld,
    output logic                      o_misalign,
    output logic                      o_buserr,
    input  logic                      i_pre_valid,
    output logic                      o_pre_ready,
    output logic                      o_post_valid,
    input  logic                      i_post_ready,
    lsu_axil_if.master                m
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    typedef logic [`LSU_OPT_WIDTH-1:0] opt_t;
    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;
    function automatic logic is_h(input opt_t op);
        return op == `LSU_LH || op == `LSU_LHU || op == `LSU_SH;
    endfunction
    function automatic logic is_w(input opt_t op);
        return op == `LSU_LW || op == `LSU_SW;
    endfunction
    state_t            r_state, w_next;
    opt_t              r_opt;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_data, r_regld;
    logic              r_misalign, r_buserr, r_aw_done, r_w_done;
    logic              w_accept, w_ld, w_st, w_mis, w_aw_hs, w_w_hs, w_aw_ok, w_w_ok;
    logic [OFF_W-1:0]  w_off;
    logic [XLEN-1:0]   w_rsh, w_ldval;
    logic [NBYTES-1:0] w_strb;
    assign w_ld     = i_opt == `LSU_LB || i_opt == `LSU_LH || i_opt == `LSU_LW ||
                      i_opt == `LSU_LBU || i_opt == `LSU_LHU;
    assign w_st     = i_opt == `LSU_SB || i_opt == `LSU_SH || i_opt == `LSU_SW;
    assign w_mis    = (is_h(i_opt) && i_addr[0]) || (is_w(i_opt) && i_addr[1:0] != 2'b00);
    assign w_accept = i_pre_valid && o_pre_ready;
    assign w_aw_hs  = m.awvalid && m.awready;
    assign w_w_hs   = m.wvalid && m.wready;
    assign w_aw_ok  = r_aw_done || w_aw_hs;
    assign w_w_ok   = r_w_done || w_w_hs;
    assign w_off    = r_addr[OFF_W-1:0];
    // Lane placement: loads shift the beat down to bit 0, stores shift data/strobe up to the byte offset
    assign w_rsh    = m.rdata >> {w_off, 3'b000};
    assign w_ldval  = r_opt == `LSU_LB  ? XLEN'($signed(w_rsh[7:0])) :
                      r_opt == `LSU_LBU ? XLEN'(w_rsh[7:0]) :
                      r_opt == `LSU_LH  ? XLEN'($signed(w_rsh[15:0])) :
                      r_opt == `LSU_LHU ? XLEN'(w_rsh[15:0]) :
                                          XLEN'($signed(w_rsh[31:0]));
    assign w_strb   = is_w(r_opt) ? NBYTES'(4'hF) : is_h(r_opt) ? NBYTES'(2'b11) : NBYTES'(1'b1);
    assign m.araddr  = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign m.awaddr  = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign m.wdata   = r_data << {w_off, 3'b000};
    assign m.wstrb   = w_strb << w_off;
    assign m.arvalid = r_state == AR;
    assign m.rready  = r_state == R;
    assign m.awvalid = r_state == AW_W && !r_aw_done;
    assign m.wvalid  = r_state == AW_W && !r_w_done;
    assign m.bready  = r_state == B;
    assign o_pre_ready  = r_state == IDLE;
    assign o_post_valid = r_state == RESP;
    assign o_regld      = r_regld;
    assign o_misalign   = r_misalign;
    assign o_buserr     = r_buserr;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_pre_valid) w_next = (!w_ld && !w_st) || w_mis ? RESP : w_ld ? AR : AW_W;
            AR:      if (m.arready) w_next = R;
            R:       if (m.rvalid) w_next = RESP;
            AW_W:    if (w_aw_ok && w_w_ok) w_next = B;
            B:       if (m.bvalid) w_next = RESP;
            RESP:    if (i_post_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opt      <= `LSU_NOP;
            r_addr     <= '0;
            r_data     <= '0;
            r_regld    <= '0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else if (w_accept) begin
            r_opt      <= i_opt;
            r_addr     <= i_addr;
            r_data     <= i_regst;
            r_regld    <= '0;
            r_misalign <= w_mis;
            r_buserr   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs) r_w_done <= 1'b1;
            if (r_state == R && m.rvalid) begin
                r_regld  <= w_ldval;
                r_buserr <= |m.rresp;
            end
            if (r_state == B && m.bvalid) begin
                r_regld  <= '0;
                r_buserr <= |m.bresp;
            end
        end
    end
endmodule

// File: tb/tb_lsu_axil.sv
// tb_lsu_axil: vector table plus scoreboard against a configurable-latency AXI4-Lite slave
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 4
`define LSU_NOP 4'b0000
`define LSU_LB  4'b0010
`define LSU_LH  4'b0100
`define LSU_LW  4'b0110
`define LSU_LBU 4'b1000
`define LSU_LHU 4'b1010
`define LSU_SB  4'b0011
`define LSU_SH  4'b0101
`define LSU_SW  4'b0111
`endif
module tb_lsu_axil;
    typedef struct {
        logic [3:0]  opt;
        logic [31:0] addr, regst, rdata;
        logic [1:0]  rresp, bresp;
        int          ar_dly, aw_dly, w_dly, hold;
        logic [31:0] exp_regld;
        logic        exp_mis, exp_berr;
        logic [31:0] exp_axaddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        int          exp_lat, exp_hs;
    } vec_t;
    typedef struct {
        logic [31:0] regld;
        logic        mis, berr;
    } res_t;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [3:0]  opt = `LSU_NOP;
    logic [31:0] addr = '0, regst = '0, regld;
    logic        pre_valid = 1'b0, post_ready = 1'b1, pre_ready, post_valid, mis, berr;
    int          ar_dly = 0, aw_dly = 0, w_dly = 0, ar_cnt, aw_cnt, w_cnt, n_hs;
    logic [31:0] slv_rdata = '0, last_araddr, last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    logic [1:0]  slv_rresp = '0, slv_bresp = '0;
    logic        aw_got, w_got, aw_hs, w_hs, ar_hs;
    int          n_vec = 0, n_err = 0;
    res_t        sb[$];
    vec_t        v[$];
    always #5 clk = ~clk;
    lsu_axil_if #(.XLEN(32), .ADDR_W(32)) axi ();
    lsu_axil #(.XLEN(32), .ADDR_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opt(opt), .i_addr(addr), .i_regst(regst),
        .o_regld(regld), .o_misalign(mis), .o_buserr(berr),
        .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
        .o_post_valid(post_valid), .i_post_ready(post_ready), .m(axi.master)
    );
    assign axi.arready = axi.arvalid && (ar_cnt >= ar_dly);
    assign axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && (w_cnt >= w_dly);
    assign ar_hs = axi.arvalid && axi.arready;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; n_hs <= 0;
            axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= '0;
            axi.bvalid <= 1'b0; axi.bresp <= '0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
            n_hs   <= n_hs + int'(ar_hs) + int'(aw_hs) + int'(w_hs);
            if (ar_hs) begin
                axi.rvalid <= 1'b1; axi.rdata <= slv_rdata; axi.rresp <= slv_rresp;
                last_araddr <= axi.araddr;
            end else if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
            if (aw_hs) last_awaddr <= axi.awaddr;
            if (w_hs) begin last_wdata <= axi.wdata; last_wstrb <= axi.wstrb; end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                axi.bvalid <= 1'b1; axi.bresp <= slv_bresp; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs) w_got <= 1'b1;
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic run(input vec_t t);
        int lat, hs0;
        res_t e;
        logic [31:0] mask;
        @(negedge clk);
        ar_dly = t.ar_dly; aw_dly = t.aw_dly; w_dly = t.w_dly;
        slv_rdata = t.rdata; slv_rresp = t.rresp; slv_bresp = t.bresp;
        opt = t.opt; addr = t.addr; regst = t.regst;
        post_ready = (t.hold == 0);
        pre_valid = 1'b1;
        hs0 = n_hs;
        chk("pre_ready_idle", 32'(pre_ready), 32'd1);
        sb.push_back('{t.exp_regld, t.exp_mis, t.exp_berr});
        lat = 0;
        do begin
            @(negedge clk);
            pre_valid = 1'b0;
            lat++;
        end while (!post_valid && lat < 50);
        chk("latency", 32'(lat), 32'(t.exp_lat));
        e = sb.pop_front();
        for (int i = 0; i <= t.hold; i++) begin
            chk("regld", regld, e.regld);
            chk("misalign", 32'(mis), 32'(e.mis));
            chk("buserr", 32'(berr), 32'(e.berr));
            chk("post_valid", 32'(post_valid), 32'd1);
            chk("pre_ready_busy", 32'(pre_ready), 32'd0);
            if (i == t.hold) post_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        chk("post_once", 32'(post_valid), 32'd0);
        chk("axi_handshakes", 32'(n_hs - hs0), 32'(t.exp_hs));
        mask = '0;
        for (int b = 0; b < 4; b++) if (t.exp_strb[b]) mask[8*b +: 8] = 8'hFF;
        if (t.exp_hs == 1) chk("araddr", last_araddr, t.exp_axaddr);
        if (t.exp_hs == 2) begin
            chk("awaddr", last_awaddr, t.exp_axaddr);
            chk("wstrb", 32'(last_wstrb), 32'(t.exp_strb));
            chk("wdata", last_wdata & mask, t.exp_wdata);
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        // opt addr regst rdata rresp bresp ar aw w hold | regld mis berr axaddr strb wdata lat hs
        v.push_back('{`LSU_LW,  32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 2'd0, 2'd0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h8000_0004, 4'h0, 32'h0, 3, 1});
        v.push_back('{`LSU_LB,  32'h8000_0003, 32'h0, 32'h8012_3456, 2'd0, 2'd0, 0, 0, 0, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 3, 1});
        v.push_back('{`LSU_LBU, 32'h8000_0003, 32'h0, 32'h8012_3456, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0000_0080, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 3, 1});
        v.push_back('{`LSU_LHU, 32'h8000_0002, 32'h0, 32'h8012_3456, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0000_8012, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 3, 1});
        v.push_back('{`LSU_LH,  32'h8000_0002, 32'h0, 32'h8012_3456, 2'd0, 2'd0, 0, 0, 0, 0, 32'hFFFF_8012, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 3, 1});
        v.push_back('{`LSU_LB,  32'h8000_0001, 32'h0, 32'h8012_3456, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0000_0034, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 3, 1});
        v.push_back('{`LSU_LW,  32'h8000_0008, 32'h0, 32'h1234_5678, 2'd2, 2'd0, 0, 0, 0, 5, 32'h1234_5678, 1'b0, 1'b1, 32'h8000_0008, 4'h0, 32'h0, 3, 1});
        v.push_back('{`LSU_SB,  32'h0000_1002, 32'h0000_00AB, 32'h0, 2'd0, 2'd0, 0, 2, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0000_1000, 4'b0100, 32'h00AB_0000, 5, 2});
        v.push_back('{`LSU_SH,  32'h0000_1002, 32'h0000_BEEF, 32'h0, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0000_1000, 4'b1100, 32'hBEEF_0000, 3, 2});
        v.push_back('{`LSU_SW,  32'h0000_1004, 32'hCAFE_F00D, 32'h0, 2'd0, 2'd3, 0, 0, 0, 0, 32'h0, 1'b0, 1'b1, 32'h0000_1004, 4'b1111, 32'hCAFE_F00D, 3, 2});
        v.push_back('{`LSU_SH,  32'h0000_1001, 32'h0000_1234, 32'h0, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1, 0});
        v.push_back('{`LSU_LW,  32'h0000_1002, 32'h0, 32'h5555_5555, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1, 0});
        v.push_back('{`LSU_LH,  32'h0000_1003, 32'h0, 32'h5555_5555, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1, 0});
        v.push_back('{`LSU_NOP, 32'h0000_1003, 32'hFFFF_FFFF, 32'h0, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 0});
        v.push_back('{`LSU_LW,  32'h0000_2000, 32'h0, 32'h0BAD_F00D, 2'd0, 2'd0, 2, 0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 5, 1});
        v.push_back('{`LSU_SW,  32'h0000_3008, 32'h1122_3344, 32'h0, 2'd0, 2'd0, 0, 0, 3, 0, 32'h0, 1'b0, 1'b0, 32'h0000_3008, 4'b1111, 32'h1122_3344, 6, 2});
        v.push_back('{`LSU_SB,  32'h0000_3003, 32'hFFFF_FF5A, 32'h0, 2'd0, 2'd0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0000_3000, 4'b1000, 32'h5A00_0000, 3, 2});
        #1 rst_n = 1'b0;
        #1;
        chk("rst_post_valid", 32'(post_valid), 32'd0);
        chk("rst_regld", regld, 32'h0);
        chk("rst_flags", {30'd0, mis, berr}, 32'd0);
        chk("rst_valids", {28'd0, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
        chk("rst_rready", 32'(axi.rready), 32'd0);
        chk("rst_pre_ready", 32'(pre_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        foreach (v[i]) run(v[i]);
        // Reset dropped while a read address is still waiting for arready
        @(negedge clk);
        ar_dly = 10; opt = `LSU_LW; addr = 32'h8000_0010; pre_valid = 1'b1;
        @(negedge clk);
        pre_valid = 1'b0;
        chk("ar_pending", 32'(axi.arvalid), 32'd1);
        chk("ar_busy", 32'(pre_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_arvalid", 32'(axi.arvalid), 32'd0);
        chk("async_pre_ready", 32'(pre_ready), 32'd1);
        chk("async_post_valid", 32'(post_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ar_dly = 0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_rst", {30'd0, post_valid, axi.arvalid}, 32'd0);
        end
        run(v[0]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
